// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit. The EX stage imports this
// package for the MDFunc encoding it drives onto md_unit.func.
package md_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_NOP  = 3'b000,
    MD_MULT = 3'b001,
    MD_DIV  = 3'b010,
    MD_MTHI = 3'b011,
    MD_MTLO = 3'b100
  } md_func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. Used as |x| on operand entry and as
// the final sign correction of product, quotient and remainder.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, operating on
// magnitudes with the sign applied in a final FIX cycle.
// Optional macro MD_FAST_MUL_EN: MULT uses a single-cycle multiplier instead
// of the iterative path; DIV is unaffected.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN        = MD_XLEN,
  parameter int ITER_CYCLES = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_func_t        func,
  input  logic            is_sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER_CYCLES + 1);

  md_state_t         r_state, w_state_nxt;
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;   // MUL: {partial, multiplier}; DIV: {rem, quo}
  logic [XLEN-1:0]   r_b, w_b_nxt;
  logic [XLEN-1:0]   r_hi, w_hi_nxt;
  logic [XLEN-1:0]   r_lo, w_lo_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_sgn_q, w_sgn_q_nxt;  // sign of product / quotient
  logic              r_sgn_r, w_sgn_r_nxt;  // sign of remainder
  logic              r_dz, w_dz_nxt;
  logic              r_is_div, w_is_div_nxt;
  logic              r_done, w_done_nxt;

  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;
  logic [XLEN:0]     w_madd, w_shift, w_diff;
  logic [2*XLEN-1:0] w_mul_step, w_div_step;
  logic              w_last;

  md_sign_fix #(.W(XLEN)) u_abs_a (
    .i_val(a), .i_neg(is_sign & a[XLEN-1]), .o_val(w_abs_a)
  );
  md_sign_fix #(.W(XLEN)) u_abs_b (
    .i_val(b), .i_neg(is_sign & b[XLEN-1]), .o_val(w_abs_b)
  );
  md_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_sgn_q), .o_val(w_prod_fix)
  );
  md_sign_fix #(.W(XLEN)) u_fix_quo (
    .i_val(r_acc[XLEN-1:0]), .i_neg(r_sgn_q), .o_val(w_quo_fix)
  );
  md_sign_fix #(.W(XLEN)) u_fix_rem (
    .i_val(r_acc[2*XLEN-1:XLEN]), .i_neg(r_sgn_r), .o_val(w_rem_fix)
  );

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_madd     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_mul_step = {w_madd, r_acc[XLEN-1:1]};

  // Restoring divide: remainder is always below the divisor, so the shifted
  // value fits in XLEN+1 bits and the top bit of the difference is the borrow.
  assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_div_step = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  assign w_last = (r_cnt == CW'(ITER_CYCLES - 1));

`ifdef MD_FAST_MUL_EN
  // Low 2*XLEN bits of the product of extended operands are exact for both
  // signed and unsigned interpretations.
  logic [2*XLEN-1:0] w_fa, w_fb, w_fprod;
  assign w_fa    = {{XLEN{is_sign & a[XLEN-1]}}, a};
  assign w_fb    = {{XLEN{is_sign & b[XLEN-1]}}, b};
  assign w_fprod = w_fa * w_fb;
`endif

  // Next-state and datapath update; cancel in any busy state wins.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_b_nxt      = r_b;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_cnt_nxt    = r_cnt;
    w_sgn_q_nxt  = r_sgn_q;
    w_sgn_r_nxt  = r_sgn_r;
    w_dz_nxt     = r_dz;
    w_is_div_nxt = r_is_div;
    w_done_nxt   = 1'b0;
    if (r_state != IDLE && cancel) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !cancel) begin
            w_acc_nxt   = {{XLEN{1'b0}}, w_abs_a};
            w_b_nxt     = w_abs_b;
            w_cnt_nxt   = '0;
            w_sgn_q_nxt = is_sign & (a[XLEN-1] ^ b[XLEN-1]);
            w_sgn_r_nxt = is_sign & a[XLEN-1];
            w_dz_nxt    = (b == '0);
            case (func)
              MD_MULT: begin
`ifdef MD_FAST_MUL_EN
                w_hi_nxt   = w_fprod[2*XLEN-1:XLEN];
                w_lo_nxt   = w_fprod[XLEN-1:0];
                w_done_nxt = 1'b1;
`else
                w_is_div_nxt = 1'b0;
                w_state_nxt  = MUL;
`endif
              end
              MD_DIV: begin
                w_is_div_nxt = 1'b1;
                w_state_nxt  = DIV;
              end
              MD_MTHI: w_hi_nxt = a;
              MD_MTLO: w_lo_nxt = a;
              default: ;
            endcase
          end
        end
        MUL: begin
          w_acc_nxt = w_mul_step;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) w_state_nxt = FIX;
        end
        DIV: begin
          w_acc_nxt = w_div_step;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) w_state_nxt = FIX;
        end
        FIX: begin
          if (r_is_div) begin
            w_hi_nxt = w_rem_fix;
            w_lo_nxt = r_dz ? {XLEN{1'b1}} : w_quo_fix;
          end else begin
            w_hi_nxt = w_prod_fix[2*XLEN-1:XLEN];
            w_lo_nxt = w_prod_fix[XLEN-1:0];
          end
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_sgn_q  <= 1'b0;
      r_sgn_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_b      <= w_b_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sgn_q  <= w_sgn_q_nxt;
      r_sgn_r  <= w_sgn_r_nxt;
      r_dz     <= w_dz_nxt;
      r_is_div <= w_is_div_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide responder with architectural HI/LO registers for the MIPS pipeline.
- The EX stage is the initiator: it issues a one-cycle start with operands and a function code, then reads HI/LO when busy is low.
- Sits beside the ALU; busy feeds stall detection so that mfhi/mflo and new MD ops wait.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER_CYCLES, 32, iterations per mult/div; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request valid for one cycle, from EX
- func  in  3  operation code (md_pkg::md_func_t)
- is_sign  in  1  signed (1) or unsigned (0) operands for MULT/DIV
- a  in  XLEN  forwarded rs operand
- b  in  XLEN  forwarded rt operand
- cancel  in  1  EX flush; aborts an in-flight op
- busy  out  1  op in progress; HI/LO not valid for reading
- done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, working registers=0.
- Function codes:
  - 000 NOP
  - 001 MULT: {hi,lo} = a*b
  - 010 DIV: lo = a/b, hi = a%b
  - 011 MTHI: hi = a
  - 100 MTLO: lo = a
  - 101–111 treated as NOP
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start + MULT/DIV:
  - Latch |a| and |b| (absolute values when is_sign, raw otherwise).
  - Latch the result sign: sign(a)^sign(b) for the product and quotient, sign(a) for the remainder.
  - Counter=0; go to MUL or DIV. busy=1 from the next cycle.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator. After ITER_CYCLES iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle. After ITER_CYCLES iterations go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write hi/lo, pulse done=1, busy=0 on the same edge; return to IDLE.
- Latency: start at edge N gives hi/lo valid and done high after edge N+ITER_CYCLES+1 (33 cycles for XLEN=32). busy is high for exactly ITER_CYCLES+1 cycles.
- MTHI/MTLO in IDLE: write on the next edge. No busy, no done.
- start while busy: ignored. The initiator must stall on busy; the unit does not queue.
- cancel while busy (any non-IDLE state): return to IDLE next edge, busy=0, no done, hi/lo unchanged. cancel in IDLE is a no-op.
- cancel and start in the same cycle: cancel wins; the request is dropped.
- Divide by zero: lo=all ones, hi=a (original, unsigned/signed as given). Takes normal latency, done pulses.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF, signed): lo=0x80000000, hi=0.
- Products are full 2*XLEN wide; no truncation. Unsigned ops ignore operand sign bits.
- hi/lo are held at their last committed values during MUL/DIV; they are never partially updated.

Optional Feature:
- Macro MD_FAST_MUL_EN.
- Defined: MULT completes combinationally using the synthesised multiplier on signed/unsigned-extended operands. Result is written on the edge after start, with done pulsing that cycle and busy never asserted. DIV is unchanged.
- Undefined: MULT uses the iterative MUL path with 33-cycle latency as above.

Decomposition:
- md_pkg holds:
  - md_func_t enum (MD_NOP, MD_MULT, MD_DIV, MD_MTHI, MD_MTLO)
  - md_state_t enum (IDLE, MUL, DIV, FIX)
  - the XLEN default constant
- The same package is imported by the EX stage for the MDFunc encoding.
- One sub-module: md_sign_fix, a combinational abs/negate helper used at entry and in FIX.

Test Plan:
- MULT unsigned a=0xFFFFFFFF, b=0x2 → after 33 cycles done=1, hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 33 cycles.
- MULT signed a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV signed a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV unsigned a=100, b=7 → lo=14, hi=2.
- DIV a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, done after 33 cycles.
- MTHI a=0xCAFE0000 then MTLO a=0x0000BEEF in consecutive cycles → hi=0xCAFE0000, lo=0x0000BEEF; busy never set. Then MULT started, cancel at cycle 10 → busy drops next cycle, no done, hi/lo unchanged.
- Reset asserted mid-DIV (cycle 15) → next edge busy=0, done=0, hi=lo=0. A start issued while busy is ignored, so results match the first op only.
